// File: rtl/alu_share_arbiter_if.sv
// Bundles the two request/response channels and the ALU side bus of alu_share_arbiter.
// With ALU_OPCHECK_EN defined, each response channel also carries an err flag.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_opc;
    logic [WIDTH-1:0] req0_n;
    logic [WIDTH-1:0] req0_m;
    logic             req0_c;
    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_opc;
    logic [WIDTH-1:0] req1_n;
    logic [WIDTH-1:0] req1_m;
    logic             req1_c;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_f;
    logic             rsp0_zer;
    logic             rsp0_neg;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_f;
    logic             rsp1_zer;
    logic             rsp1_neg;
`ifdef ALU_OPCHECK_EN
    logic             rsp0_err;
    logic             rsp1_err;
`endif

    logic [2:0]       alu_opc;
    logic [WIDTH-1:0] alu_inN;
    logic [WIDTH-1:0] alu_inM;
    logic             alu_inC;
    logic [WIDTH-1:0] alu_outF;
    logic             alu_zer;
    logic             alu_neg;

    logic             busy;

    modport slave (
        input  req0_valid, req0_opc, req0_n, req0_m, req0_c,
        input  req1_valid, req1_opc, req1_n, req1_m, req1_c,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_f, rsp0_zer, rsp0_neg,
        output rsp1_valid, rsp1_f, rsp1_zer, rsp1_neg,
        input  rsp0_ready, rsp1_ready,
`ifdef ALU_OPCHECK_EN
        output rsp0_err, rsp1_err,
`endif
        output alu_opc, alu_inN, alu_inM, alu_inC,
        input  alu_outF, alu_zer, alu_neg,
        output busy
    );

    modport master (
        output req0_valid, req0_opc, req0_n, req0_m, req0_c,
        output req1_valid, req1_opc, req1_n, req1_m, req1_c,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_f, rsp0_zer, rsp0_neg,
        input  rsp1_valid, rsp1_f, rsp1_zer, rsp1_neg,
        output rsp0_ready, rsp1_ready,
`ifdef ALU_OPCHECK_EN
        input  rsp0_err, rsp1_err,
`endif
        input  alu_opc, alu_inN, alu_inM, alu_inC,
        output alu_outF, alu_zer, alu_neg,
        input  busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharer of one combinational ALU between two requesters.
// Build option ALU_OPCHECK_EN: adds rspX_err and answers opcode 3'b111 without using the ALU.
module alu_share_arbiter #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 1
) (
    input logic                clk,
    input logic                rst_n,
    alu_share_arbiter_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for a request; ready follows the round-robin grant
    // ISSUE | operand regs held on the ALU while its outputs settle
    // RESP  | captured result offered to the owner until it is taken
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t           state_q, state_d;
    logic             last_q, last_d;     // 1: req1 was served most recently
    logic             owner_q, owner_d;
    logic [2:0]       opc_q, opc_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             c_q, c_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             zer_q, zer_d;
    logic             neg_q, neg_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
`ifdef ALU_OPCHECK_EN
    logic             err_q, err_d;
`endif

    logic             ready0, ready1, rsp_take, short_op;
    logic [2:0]       sel_opc;
    logic [WIDTH-1:0] sel_n, sel_m;
    logic             sel_c;

    always_comb begin
        ready0   = (state_q == IDLE) & bus.req0_valid & (~bus.req1_valid | last_q);
        ready1   = (state_q == IDLE) & bus.req1_valid & (~bus.req0_valid | ~last_q);
        sel_opc  = ready1 ? bus.req1_opc : bus.req0_opc;
        sel_n    = ready1 ? bus.req1_n   : bus.req0_n;
        sel_m    = ready1 ? bus.req1_m   : bus.req0_m;
        sel_c    = ready1 ? bus.req1_c   : bus.req0_c;
        rsp_take = owner_q ? (rsp1_valid_q & bus.rsp1_ready) : (rsp0_valid_q & bus.rsp0_ready);
`ifdef ALU_OPCHECK_EN
        short_op = (sel_opc == 3'b111);
`else
        short_op = 1'b0;
`endif
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        opc_d        = opc_q;
        n_d          = n_q;
        m_d          = m_q;
        c_d          = c_q;
        cnt_d        = cnt_q;
        f_d          = f_q;
        zer_d        = zer_q;
        neg_d        = neg_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
`ifdef ALU_OPCHECK_EN
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (ready0 | ready1) begin
                    owner_d = ready1;
                    cnt_d   = '0;
                    if (short_op) begin
                        // illegal opcode: answered directly, ALU inputs left untouched
                        f_d          = '0;
                        zer_d        = 1'b1;
                        neg_d        = 1'b0;
                        rsp0_valid_d = ~ready1;
                        rsp1_valid_d = ready1;
                        state_d      = RESP;
`ifdef ALU_OPCHECK_EN
                        err_d        = 1'b1;
`endif
                    end else begin
                        opc_d   = sel_opc;
                        n_d     = sel_n;
                        m_d     = sel_m;
                        c_d     = sel_c;
                        state_d = ISSUE;
`ifdef ALU_OPCHECK_EN
                        err_d   = 1'b0;
`endif
                    end
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    f_d          = bus.alu_outF;
                    zer_d        = bus.alu_zer;
                    neg_d        = bus.alu_neg;
                    rsp0_valid_d = ~owner_q;
                    rsp1_valid_d = owner_q;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_take) begin
                    last_d       = owner_q;
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            opc_q        <= '0;
            n_q          <= '0;
            m_q          <= '0;
            c_q          <= 1'b0;
            cnt_q        <= '0;
            f_q          <= '0;
            zer_q        <= 1'b0;
            neg_q        <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
`ifdef ALU_OPCHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            opc_q        <= opc_d;
            n_q          <= n_d;
            m_q          <= m_d;
            c_q          <= c_d;
            cnt_q        <= cnt_d;
            f_q          <= f_d;
            zer_q        <= zer_d;
            neg_q        <= neg_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
`ifdef ALU_OPCHECK_EN
            err_q        <= err_d;
`endif
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_f     = f_q;
    assign bus.rsp1_f     = f_q;
    assign bus.rsp0_zer   = zer_q;
    assign bus.rsp1_zer   = zer_q;
    assign bus.rsp0_neg   = neg_q;
    assign bus.rsp1_neg   = neg_q;
`ifdef ALU_OPCHECK_EN
    assign bus.rsp0_err   = err_q;
    assign bus.rsp1_err   = err_q;
`endif
    assign bus.alu_opc    = opc_q;
    assign bus.alu_inN    = n_q;
    assign bus.alu_inM    = m_q;
    assign bus.alu_inC    = c_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter driven against a behavioural 16-bit ALU stand-in.
module tb_alu_share_arbiter;
    localparam int WIDTH  = 16;
    localparam int SETTLE = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(WIDTH)) bus();
    alu_share_arbiter #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // ALU stand-in: add, sub, xor, or, and, not, andn, zero
    function automatic logic [15:0] alu_fn(input logic [2:0] o, input logic [15:0] n, input logic [15:0] m, input logic c);
        case (o)
            3'd0: return n + m + 16'(c);
            3'd1: return n + ~m + 16'(c);
            3'd2: return n ^ m;
            3'd3: return n | m;
            3'd4: return n & m;
            3'd5: return ~n;
            3'd6: return n & ~m;
            default: return 16'h0000;
        endcase
    endfunction
    assign bus.alu_outF = alu_fn(bus.alu_opc, bus.alu_inN, bus.alu_inM, bus.alu_inC);
    assign bus.alu_zer  = (bus.alu_outF == 16'h0000);
    assign bus.alu_neg  = bus.alu_outF[15];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    typedef struct {
        bit          owner;
        logic [15:0] f;
        bit          z;
        bit          ng;
        bit          err;
        int          acc;
    } exp_t;
    exp_t q[$];
    int   acc_log[$];

    bit          last_srv;
    logic [2:0]  a_opc;
    logic [15:0] a_n, a_m;
    logic        a_c;

    task automatic push_exp(input bit owner, input logic [2:0] o, input logic [15:0] n, input logic [15:0] m, input logic c);
        exp_t e;
        e.owner = owner;
        e.acc   = cyc;
        e.err   = 1'b0;
        e.f     = alu_fn(o, n, m, c);
`ifdef ALU_OPCHECK_EN
        if (o == 3'b111) begin
            e.err = 1'b1;
            e.f   = 16'h0000;
        end
`endif
        e.z  = (e.f == 16'h0000);
        e.ng = e.f[15];
        if (!e.err) begin
            a_opc = o; a_n = n; a_m = m; a_c = c;
        end
        q.push_back(e);
        acc_log.push_back(int'(owner));
    endtask

    // Monitor: arbitration model, latency and result checks, scoreboard pops on rsp handshake
    bit   m_idle, m_e0, m_e1, m_rv, m_take;
    exp_t cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            last_srv = 1'b1;
            a_opc = '0; a_n = '0; a_m = '0; a_c = 1'b0;
        end else begin
            m_idle = (q.size() == 0);
            m_e0 = m_idle && bus.req0_valid && (!bus.req1_valid || last_srv);
            m_e1 = m_idle && bus.req1_valid && (!bus.req0_valid || !last_srv);
            chk("req0_ready", bus.req0_ready, m_e0);
            chk("req1_ready", bus.req1_ready, m_e1);
            chk("busy", bus.busy, !m_idle);
            if (!m_idle) begin
                cur  = q[0];
                m_rv = (cyc - cur.acc) >= (cur.err ? 1 : SETTLE + 1);
                chk("rsp0_valid", bus.rsp0_valid, m_rv && !cur.owner);
                chk("rsp1_valid", bus.rsp1_valid, m_rv && cur.owner);
                chk("alu_in", {bus.alu_opc, bus.alu_inC, bus.alu_inN, bus.alu_inM[11:0]},
                              {a_opc, a_c, a_n, a_m[11:0]});
                chk("alu_inM_hi", bus.alu_inM[15:12], a_m[15:12]);
                m_take = 1'b0;
                if (m_rv) begin
                    if (!cur.owner) begin
                        chk("rsp0_data", {bus.rsp0_zer, bus.rsp0_neg, bus.rsp0_f}, {cur.z, cur.ng, cur.f});
`ifdef ALU_OPCHECK_EN
                        chk("rsp0_err", bus.rsp0_err, cur.err);
`endif
                        m_take = bus.rsp0_ready;
                    end else begin
                        chk("rsp1_data", {bus.rsp1_zer, bus.rsp1_neg, bus.rsp1_f}, {cur.z, cur.ng, cur.f});
`ifdef ALU_OPCHECK_EN
                        chk("rsp1_err", bus.rsp1_err, cur.err);
`endif
                        m_take = bus.rsp1_ready;
                    end
                end
                if (m_take) begin
                    q.delete(0);
                    last_srv = cur.owner;
                end
            end else begin
                chk("rsp0_valid_idle", bus.rsp0_valid, 1'b0);
                chk("rsp1_valid_idle", bus.rsp1_valid, 1'b0);
            end
            if (bus.req0_valid && bus.req0_ready)
                push_exp(1'b0, bus.req0_opc, bus.req0_n, bus.req0_m, bus.req0_c);
            else if (bus.req1_valid && bus.req1_ready)
                push_exp(1'b1, bus.req1_opc, bus.req1_n, bus.req1_m, bus.req1_c);
        end
    end

    task automatic set_req(input int i, input logic v, input logic [2:0] o, input logic [15:0] n, input logic [15:0] m, input logic c);
        if (i == 0) begin
            bus.req0_valid = v; bus.req0_opc = o; bus.req0_n = n; bus.req0_m = m; bus.req0_c = c;
        end else begin
            bus.req1_valid = v; bus.req1_opc = o; bus.req1_n = n; bus.req1_m = m; bus.req1_c = c;
        end
    endtask

    function automatic logic [15:0] rnd16();
        return 16'($urandom);
    endfunction

    task automatic issue(input int i, input logic [2:0] o, input logic [15:0] n, input logic [15:0] m, input logic c, input bit may_withdraw);
        logic [2:0] ro;
        logic [15:0] rn, rm;
        ro = o; rn = n; rm = m;
        @(posedge clk); #1;
        set_req(i, 1'b1, ro, rn, rm, c);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if ((i == 0) ? bus.req0_ready : bus.req1_ready) begin
                @(posedge clk); #1;
                set_req(i, 1'b0, ro, rn, rm, c);
                return;
            end
            if (may_withdraw && $urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
                set_req(i, 1'b0, ro, rn, rm, c);
                @(posedge clk); #1;
                ro = 3'($urandom_range(0, 7)); rn = rnd16(); rm = rnd16();
                set_req(i, 1'b1, ro, rn, rm, c);
            end
        end
        checks++; errors++;
        $display("FAIL accept_timeout req%0d: never accepted, required within 400 cycles", i);
        set_req(i, 1'b0, ro, rn, rm, c);
    endtask

    task automatic rand_driver(input int i, input int nops);
        logic [15:0] n;
        for (int k = 0; k < nops; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            n = rnd16();
            issue(i, 3'($urandom_range(0, 7)), n, ($urandom_range(0, 3) == 0) ? n : rnd16(),
                  1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    task automatic wait_rsp(input int i, input logic [15:0] f, input bit z, input bit ng);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if ((i == 0) ? bus.rsp0_valid : bus.rsp1_valid) begin
                if (i == 0) chk("directed_rsp0", {bus.rsp0_zer, bus.rsp0_neg, bus.rsp0_f}, {z, ng, f});
                else        chk("directed_rsp1", {bus.rsp1_zer, bus.rsp1_neg, bus.rsp1_f}, {z, ng, f});
                return;
            end
        end
        checks++; errors++;
        $display("FAIL rsp_timeout rsp%0d: no valid, required within 60 cycles", i);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!bus.busy) return;
        end
        checks++; errors++;
        $display("FAIL idle_timeout: busy still 1, required 0 within 100 cycles");
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, {bus.req0_ready, bus.req1_ready}, 2'b00);
        chk({tag, "_rspv"}, {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
        chk({tag, "_rspd"}, {bus.rsp0_zer, bus.rsp0_neg, bus.rsp0_f}, 18'd0);
        chk({tag, "_alu"}, {bus.alu_opc, bus.alu_inC, bus.alu_inN[11:0], bus.alu_inM[11:0]}, 28'd0);
        chk({tag, "_alu_hi"}, {bus.alu_inN[15:12], bus.alu_inM[15:12]}, 8'd0);
        chk({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    bit rand_on;
    int base;
    initial begin
        set_req(0, 1'b0, 3'd0, 16'd0, 16'd0, 1'b0);
        set_req(1, 1'b0, 3'd0, 16'd0, 16'd0, 1'b0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // randomized traffic with random response back-pressure and withdrawals
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk); #1;
                    bus.rsp0_ready = ($urandom_range(0, 3) != 0);
                    bus.rsp1_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                fork
                    rand_driver(0, 25);
                    rand_driver(1, 25);
                join
                rand_on = 1'b0;
            end
        join
        @(posedge clk); #2;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        wait_idle();

        // single requester add, then negative and zero results on req1
        issue(0, 3'b000, 16'd5, 16'd7, 1'b1, 1'b0);
        wait_rsp(0, 16'd13, 1'b0, 1'b0);
        issue(1, 3'b000, 16'hFFFD, 16'h0001, 1'b0, 1'b0);
        wait_rsp(1, 16'hFFFE, 1'b0, 1'b1);
        issue(1, 3'b110, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
        wait_rsp(1, 16'h0000, 1'b1, 1'b0);
        wait_idle();

        // both requesters contending: strict alternation starting with req0
        base = acc_log.size();
        fork
            for (int k = 0; k < 4; k++) issue(0, 3'b011, 16'(k), 16'h0100, 1'b0, 1'b0);
            for (int k = 0; k < 4; k++) issue(1, 3'b010, 16'(k), 16'h8000, 1'b0, 1'b0);
        join
        wait_idle();
        chk("grant_count", acc_log.size() - base, 8);
        for (int k = 0; k < 8 && base + k < acc_log.size(); k++)
            chk($sformatf("grant_order_%0d", k), acc_log[base + k], k % 2);

        // response stall: result held, other requester locked out
        @(posedge clk); #1 bus.rsp0_ready = 1'b0;
        fork
            issue(1, 3'b000, 16'h1111, 16'h2222, 1'b0, 1'b0);
            begin
                issue(0, 3'b100, 16'h00F0, 16'h0FF0, 1'b0, 1'b0);
                wait_rsp(0, 16'h00F0, 1'b0, 1'b0);
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_valid", bus.rsp0_valid, 1'b1);
                    chk("stall_f", bus.rsp0_f, 16'h00F0);
                    chk("stall_req1_ready", bus.req1_ready, 1'b0);
                end
                @(posedge clk); #1 bus.rsp0_ready = 1'b1;
            end
        join
        wait_rsp(1, 16'h3333, 1'b0, 1'b0);
        wait_idle();

        // asynchronous reset while the ALU is being driven
        issue(0, 3'b001, 16'h1234, 16'h0F0F, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        repeat (SETTLE + 6) @(negedge clk);
        chk("no_rsp_after_reset", {bus.rsp0_valid, bus.rsp1_valid, bus.busy}, 3'b000);

        // opcode 111: short path with the check enabled, plain ALU result otherwise
        issue(0, 3'b111, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
        wait_rsp(0, 16'h0000, 1'b1, 1'b0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion before 2000000 time units");
        $fatal(1, "watchdog");
    end
endmodule
